// File: rtl/viterbi_pkg.sv
// Shared types and helpers for the K=3, 4-state Viterbi frame controller.
// Holds the controller state enum, trellis constants and the traceback step.
package viterbi_pkg;

    localparam int NUM_STATES = 4;
    localparam int K          = 3;
    localparam int DEC_W      = 4;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACCUM,
        DRAIN,
        TRACE,
        EMIT
    } state_t;

    // Predecessor of state s given its survivor decision bit d.
    function automatic logic [1:0] tb_step(input logic [1:0] s, input logic d);
        return {s[0], d};
    endfunction

endpackage

// File: rtl/viterbi_tb_unit.sv
// Survivor buffer and traceback engine for the Viterbi frame controller.
// Stores one decision vector per trellis stage, walks the survivor path
// backwards from state 0 and keeps the decoded bits in stage order.
module viterbi_tb_unit
    import viterbi_pkg::*;
#(
    parameter int FRAME_LEN = 16,
    parameter int ADDR_W    = $clog2(FRAME_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DEC_W-1:0]  wr_dec,
    input  logic              tr_init,
    input  logic              tr_en,
    input  logic [ADDR_W-1:0] tr_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_bit
);

    logic [DEC_W-1:0]     surv [FRAME_LEN];
    logic [FRAME_LEN-1:0] bitbuf;
    logic [1:0]           tr_state;

    // Capture each stage's decision vector as the datapath delivers it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            surv[wr_addr] <= wr_dec;
        end
    end

    // Traceback state: parked at 0 before the walk, then one predecessor per step.
    always_ff @(posedge clk) begin
        if (rst) begin
            tr_state <= 2'b00;
        end else if (tr_init) begin
            tr_state <= 2'b00;
        end else if (tr_en) begin
            tr_state <= tb_step(tr_state, surv[tr_addr][tr_state]);
        end
    end

    // The MSB of the state reached after stage t is the bit decoded for stage t.
    always_ff @(posedge clk) begin
        if (tr_en) begin
            bitbuf[tr_addr] <= tr_state[1];
        end
    end

    assign rd_bit = bitbuf[rd_addr];

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// Frame controller for the K=3, 4-state Viterbi decoder.
// Accepts symbol pairs, sequences the ACS datapath, collects decisions,
// runs traceback from state 0 and emits decoded bits in forward order.
// Optional feature macro: VITERBI_FRAME_CTRL_FCNT_EN adds a saturating
// completed-frame counter on output frame_cnt.
module viterbi_frame_ctrl
    import viterbi_pkg::*;
#(
    parameter int FRAME_LEN = 16,
    parameter int TAIL_LEN  = 2,
    parameter int ACS_LAT   = 3,
    parameter int SYM_W     = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             frame_start,
    input  logic             sym_valid,
    output logic             sym_ready,
    input  logic [SYM_W-1:0] sym_a,
    input  logic [SYM_W-1:0] sym_b,
    output logic             acs_en,
    output logic             acs_clr,
    output logic [SYM_W-1:0] acs_r3,
    output logic [SYM_W-1:0] acs_r4,
    input  logic [DEC_W-1:0] dec_vec,
    output logic             bit_valid,
    input  logic             bit_ready,
    output logic             bit_out,
    output logic             bit_last,
    output logic             busy
`ifdef VITERBI_FRAME_CTRL_FCNT_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);

    localparam int CNT_W    = $clog2(FRAME_LEN + 1);
    localparam int ADDR_W   = $clog2(FRAME_LEN);
    localparam int EMIT_LEN = FRAME_LEN - TAIL_LEN;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   issue_cnt;
    logic [CNT_W-1:0]   wr_idx;
    logic [CNT_W-1:0]   emit_idx;
    logic [ADDR_W-1:0]  trace_idx;
    logic [ACS_LAT-1:0] pend;
    logic               transfer;
    logic               mark;
    logic               bit_hs;
    logic               rd_bit;

    assign transfer = sym_valid && (state == ACCUM);
    assign bit_hs   = bit_ready && (state == EMIT);
    assign mark     = pend[ACS_LAT-1];
    assign bit_out  = bit_valid & rd_bit;

    // State register; reset aborts any frame in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and the handshake/strobe outputs that follow the state.
    always_comb begin
        state_nxt = state;
        sym_ready = 1'b0;
        acs_clr   = 1'b0;
        bit_valid = 1'b0;
        bit_last  = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (frame_start) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                acs_clr   = 1'b1;
                state_nxt = ACCUM;
            end
            ACCUM: begin
                sym_ready = 1'b1;
                if (sym_valid && (issue_cnt == CNT_W'(FRAME_LEN - 1))) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (wr_idx == CNT_W'(FRAME_LEN)) begin
                    state_nxt = TRACE;
                end
            end
            TRACE: begin
                if (trace_idx == '0) begin
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                bit_valid = 1'b1;
                bit_last  = (emit_idx == CNT_W'(EMIT_LEN - 1));
                if (bit_ready && bit_last) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Issue stage: register the accepted pair and strobe the datapath one cycle later.
    always_ff @(posedge CLK) begin
        if (RST) begin
            acs_en    <= 1'b0;
            acs_r3    <= '0;
            acs_r4    <= '0;
            issue_cnt <= '0;
        end else begin
            acs_en <= transfer;
            if (transfer) begin
                acs_r3 <= sym_a;
                acs_r4 <= sym_b;
            end
            if (state == CLEAR) begin
                issue_cnt <= '0;
            end else if (transfer) begin
                issue_cnt <= issue_cnt + CNT_W'(1);
            end
        end
    end

    // Delay line of issue strobes marks the cycle each dec_vec becomes valid.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pend   <= '0;
            wr_idx <= '0;
        end else begin
            pend <= (pend << 1) | ACS_LAT'(acs_en);
            if (state == CLEAR) begin
                wr_idx <= '0;
            end else if (mark) begin
                wr_idx <= wr_idx + CNT_W'(1);
            end
        end
    end

    // Traceback walks stages from the last one down; emit index restarts before EMIT.
    always_ff @(posedge CLK) begin
        if (RST) begin
            trace_idx <= '0;
            emit_idx  <= '0;
        end else begin
            if (state == DRAIN) begin
                trace_idx <= ADDR_W'(FRAME_LEN - 1);
            end else if (state == TRACE) begin
                trace_idx <= trace_idx - ADDR_W'(1);
            end
            if (state == TRACE) begin
                emit_idx <= '0;
            end else if (bit_hs) begin
                emit_idx <= emit_idx + CNT_W'(1);
            end
        end
    end

`ifdef VITERBI_FRAME_CTRL_FCNT_EN
    // Count completed frames, sticking at the top value instead of wrapping.
    always_ff @(posedge CLK) begin
        if (RST) begin
            frame_cnt <= '0;
        end else if (bit_hs && bit_last && (frame_cnt != 16'hFFFF)) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

    viterbi_tb_unit #(
        .FRAME_LEN (FRAME_LEN),
        .ADDR_W    (ADDR_W)
    ) u_tb_unit (
        .clk     (CLK),
        .rst     (RST),
        .wr_en   (mark),
        .wr_addr (wr_idx[ADDR_W-1:0]),
        .wr_dec  (dec_vec),
        .tr_init (state == DRAIN),
        .tr_en   (state == TRACE),
        .tr_addr (trace_idx),
        .rd_addr (emit_idx[ADDR_W-1:0]),
        .rd_bit  (rd_bit)
    );

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Self-checking bench for viterbi_frame_ctrl.
// Frames are built from random messages (zero tail); decision vectors are
// derived from the encoder state path so the decoded bits must equal the message.
module tb_viterbi_frame_ctrl;

    localparam int FRAME_LEN = 16;
    localparam int TAIL_LEN  = 2;
    localparam int ACS_LAT   = 3;
    localparam int SYM_W     = 8;
    localparam int EMIT_LEN  = FRAME_LEN - TAIL_LEN;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             frame_start = 1'b0;
    logic             sym_valid = 1'b0;
    logic             sym_ready;
    logic [SYM_W-1:0] sym_a = '0;
    logic [SYM_W-1:0] sym_b = '0;
    logic             acs_en;
    logic             acs_clr;
    logic [SYM_W-1:0] acs_r3;
    logic [SYM_W-1:0] acs_r4;
    logic [3:0]       dec_vec;
    logic             bit_valid;
    logic             bit_ready = 1'b0;
    logic             bit_out;
    logic             bit_last;
    logic             busy;
`ifdef VITERBI_FRAME_CTRL_FCNT_EN
    logic [15:0]      frame_cnt;
`endif

    viterbi_frame_ctrl #(
        .FRAME_LEN (FRAME_LEN),
        .TAIL_LEN  (TAIL_LEN),
        .ACS_LAT   (ACS_LAT),
        .SYM_W     (SYM_W)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .frame_start (frame_start),
        .sym_valid   (sym_valid),
        .sym_ready   (sym_ready),
        .sym_a       (sym_a),
        .sym_b       (sym_b),
        .acs_en      (acs_en),
        .acs_clr     (acs_clr),
        .acs_r3      (acs_r3),
        .acs_r4      (acs_r4),
        .dec_vec     (dec_vec),
        .bit_valid   (bit_valid),
        .bit_ready   (bit_ready),
        .bit_out     (bit_out),
        .bit_last    (bit_last),
        .busy        (busy)
`ifdef VITERBI_FRAME_CTRL_FCNT_EN
        ,
        .frame_cnt   (frame_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_cnt++;
        if (observed !== expected) begin
            fail_cnt++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] outVec();
        return {9'd0, sym_ready, acs_en, acs_clr, acs_r3, acs_r4, bit_valid, bit_out, bit_last, busy};
    endfunction

    // Datapath stand-in: returns each stage's decisions ACS_LAT cycles after its strobe.
    logic [3:0]       dvec [0:FRAME_LEN-1];
    logic [ACS_LAT:0] en_hist;
    int               stage_k;

    always @(negedge CLK) begin
        if (RST || acs_clr) begin
            en_hist = '0;
            stage_k = 0;
            dec_vec = 4'($urandom);
        end else begin
            en_hist = {en_hist[ACS_LAT-1:0], acs_en};
            if (en_hist[ACS_LAT] && stage_k < FRAME_LEN) begin
                dec_vec = dvec[stage_k];
                stage_k++;
            end else begin
                dec_vec = 4'($urandom);
            end
        end
    end

    // Observer: records issued pairs, emitted bits, stalls and event times.
    int          cyc_n = 0, n_xfer = 0, n_acs = 0, n_clr = 0, n_bits = 0, stall_err = 0;
    int          last_en_cyc = 0, first_bv_cyc = 0;
    logic [15:0] iss_pair [0:1023];
    logic        rx_bit   [0:1023];
    logic        rx_last  [0:1023];
    logic        prev_bv = 1'b0, prev_stall = 1'b0;
    logic [1:0]  held = 2'b00;

    always @(negedge CLK) begin
        cyc_n++;
        if (!RST) begin
            if (sym_valid && sym_ready) n_xfer++;
            if (acs_en) begin
                iss_pair[n_acs % 1024] = {acs_r3, acs_r4};
                n_acs++;
                last_en_cyc = cyc_n;
            end
            if (acs_clr) n_clr++;
            if (bit_valid && !prev_bv) first_bv_cyc = cyc_n;
            if (prev_stall && bit_valid && ({bit_out, bit_last} !== held)) stall_err++;
            if (bit_valid && bit_ready) begin
                rx_bit[n_bits % 1024]  = bit_out;
                rx_last[n_bits % 1024] = bit_last;
                n_bits++;
            end
            prev_stall = bit_valid && !bit_ready;
            held       = {bit_out, bit_last};
            prev_bv    = bit_valid;
        end else begin
            prev_stall = 1'b0;
            prev_bv    = 1'b0;
        end
    end

    int fcnt_model = 0;

    task automatic applyStimulus(input int f, input int mode, input bit toggle,
                                 input bit stall, input bit abort, input bit noise);
        logic [FRAME_LEN-1:0] u;
        logic [FRAME_LEN-1:0] exp_bits;
        logic [15:0]          exp_pair [0:FRAME_LEN-1];
        logic [1:0]           st;
        logic [3:0]           dv;
        logic                 exp_ready;
        int b_xfer, b_acs, b_clr, b_bits, b_stall;
        int acc_cnt = 0;
        int stall_left = 5;
        int after_issue = 0;
        bit done = 1'b0;

        u = '0;
        for (int t = 0; t < EMIT_LEN; t++) u[t] = 1'($urandom_range(0, 1));
        for (int t = 0; t < FRAME_LEN; t++) begin
            st = {u[t], (t >= 1) ? u[t-1] : 1'b0};
            dv = 4'($urandom);
            dv[st] = (t >= 2) ? u[t-2] : 1'b0;
            case (mode)
                0:       dvec[t] = 4'h0;
                1:       dvec[t] = 4'hF;
                default: dvec[t] = dv;
            endcase
        end
        case (mode)
            0:       exp_bits = '0;
            1:       exp_bits = '1;
            default: exp_bits = u;
        endcase

        b_xfer = n_xfer; b_acs = n_acs; b_clr = n_clr; b_bits = n_bits; b_stall = stall_err;

        for (int cyc = 0; cyc < 600 && !done; cyc++) begin
            @(posedge CLK);
            #1;
            if (RST) begin
                checkOutput($sformatf("f%0d_abort_reset_outputs", f), outVec(), 0);
                RST = 1'b0;
                fcnt_model = 0;
                done = 1'b1;
            end else if (cyc >= 2 && !busy) begin
                done = 1'b1;
            end else begin
                exp_ready = (cyc >= 2) && (acc_cnt < FRAME_LEN);
                checkOutput($sformatf("f%0d_c%0d_sym_ready", f, cyc), 32'(sym_ready), 32'(exp_ready));
                frame_start = (cyc == 0) || (noise && busy && (cyc == 4 || $urandom_range(0, 7) == 0));
                sym_valid   = toggle ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
                sym_a       = SYM_W'($urandom);
                sym_b       = SYM_W'($urandom);
                if (exp_ready && sym_valid) begin
                    exp_pair[acc_cnt] = {sym_a, sym_b};
                    acc_cnt++;
                end
                if (stall && (n_bits - b_bits) == 5 && stall_left > 0) begin
                    bit_ready = 1'b0;
                    stall_left--;
                end else begin
                    bit_ready = ($urandom_range(0, 3) != 0);
                end
                if (abort) begin
                    if (n_acs - b_acs == FRAME_LEN) after_issue++;
                    if (after_issue == 7) RST = 1'b1;
                end
            end
        end
        frame_start = 1'b0;
        sym_valid   = 1'b0;
        bit_ready   = 1'b0;

        checkOutput($sformatf("f%0d_done", f), 32'(done), 1);
        checkOutput($sformatf("f%0d_xfer_count", f), 32'(n_xfer - b_xfer), FRAME_LEN);
        checkOutput($sformatf("f%0d_acs_en_count", f), 32'(n_acs - b_acs), FRAME_LEN);
        checkOutput($sformatf("f%0d_clr_count", f), 32'(n_clr - b_clr), 1);
        for (int i = 0; i < FRAME_LEN; i++)
            checkOutput($sformatf("f%0d_acs_pair%0d", f, i), 32'(iss_pair[(b_acs + i) % 1024]), 32'(exp_pair[i]));

        if (!abort) begin
            checkOutput($sformatf("f%0d_bit_count", f), 32'(n_bits - b_bits), EMIT_LEN);
            for (int i = 0; i < EMIT_LEN; i++)
                checkOutput($sformatf("f%0d_bit%0d", f, i),
                            32'({rx_last[(b_bits + i) % 1024], rx_bit[(b_bits + i) % 1024]}),
                            32'({(i == EMIT_LEN - 1), exp_bits[i]}));
            checkOutput($sformatf("f%0d_latency", f), 32'(first_bv_cyc - last_en_cyc), ACS_LAT + FRAME_LEN + 2);
            checkOutput($sformatf("f%0d_stall_stable", f), 32'(stall_err - b_stall), 0);
            if (fcnt_model < 16'hFFFF) fcnt_model++;
        end else begin
            repeat (2) @(posedge CLK);
            #1;
            checkOutput($sformatf("f%0d_abort_idle", f), 32'({busy, bit_valid, sym_ready}), 0);
            checkOutput($sformatf("f%0d_abort_no_bits", f), 32'(n_bits - b_bits), 0);
        end
`ifdef VITERBI_FRAME_CTRL_FCNT_EN
        checkOutput($sformatf("f%0d_frame_cnt", f), 32'(frame_cnt), 32'(fcnt_model));
`endif
    endtask

    initial begin
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("reset_outputs", outVec(), 0);
`ifdef VITERBI_FRAME_CTRL_FCNT_EN
        checkOutput("reset_frame_cnt", 32'(frame_cnt), 0);
`endif
        RST = 1'b0;

        for (int f = 0; f < 10; f++) begin
            applyStimulus(f, (f == 0) ? 0 : (f == 1) ? 1 : 2,
                          (f == 2), (f == 3), (f == 4), (f >= 5));
        end

        repeat (3) @(posedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
